// File: rtl/dmem_arb.sv
// Two-port arbiter and access sequencer for the single-port data memory.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins simultaneous requests.
module dmem_arb #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               p0_req_valid,
  output logic               p0_req_ready,
  input  logic               p0_req_we,
  input  logic [WIDTH-1:0]   p0_req_addr,
  input  logic [1:0]         p0_req_size,
  input  logic               p0_req_unsigned,
  input  logic [WIDTH-1:0]   p0_req_wdata,
  output logic               p0_resp_valid,
  output logic [WIDTH-1:0]   p0_resp_rdata,
  output logic               p0_resp_err,

  input  logic               p1_req_valid,
  output logic               p1_req_ready,
  input  logic               p1_req_we,
  input  logic [WIDTH-1:0]   p1_req_addr,
  input  logic [1:0]         p1_req_size,
  input  logic               p1_req_unsigned,
  input  logic [WIDTH-1:0]   p1_req_wdata,
  output logic               p1_resp_valid,
  output logic [WIDTH-1:0]   p1_resp_rdata,
  output logic               p1_resp_err,

  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH-3:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [3:0]         mem_byteen,
  input  logic [WIDTH-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic             rr_ptr;
  logic             mem_write_q;

  logic             req_port;
  logic             req_we;
  logic             req_uns;
  logic             req_err;
  logic [1:0]       req_off;
  logic [1:0]       req_size;

  logic             pick1;
  logic             accept;
  logic             sel_we;
  logic             sel_uns;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [1:0]       sel_size;
  logic             sel_ok;
  logic [WIDTH-1:0] load_val;

  function automatic logic is_aligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return ~off[0];
      2'd2:    return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] lane_data(input logic [WIDTH-1:0] wdata,
                                                 input logic [1:0] size);
    case (size)
      2'd0:    return {(WIDTH/8){wdata[7:0]}};
      2'd1:    return {(WIDTH/16){wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Right-justify the addressed lane, then sign- or zero-extend to full width.
  function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0] word,
                                                   input logic [1:0] off,
                                                   input logic [1:0] size,
                                                   input logic uns);
    logic [WIDTH-1:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {off, 3'b000};
    b  = $signed(sh[7:0]);
    h  = $signed(sh[15:0]);
    case (size)
      2'd0:    return uns ? {{(WIDTH-8){1'b0}}, sh[7:0]}   : {{(WIDTH-8){b[7]}}, b};
      2'd1:    return uns ? {{(WIDTH-16){1'b0}}, sh[15:0]} : {{(WIDTH-16){h[15]}}, h};
      default: return sh;
    endcase
  endfunction

  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pick1 = p1_req_valid & ~p0_req_valid;
`else
    pick1 = p0_req_valid ? (p1_req_valid & rr_ptr) : (p1_req_valid | rr_ptr);
`endif
    accept    = (state == IDLE) & (pick1 ? p1_req_valid : p0_req_valid);
    sel_we    = pick1 ? p1_req_we       : p0_req_we;
    sel_uns   = pick1 ? p1_req_unsigned : p0_req_unsigned;
    sel_addr  = pick1 ? p1_req_addr     : p0_req_addr;
    sel_wdata = pick1 ? p1_req_wdata    : p0_req_wdata;
    sel_size  = pick1 ? p1_req_size     : p0_req_size;
    sel_ok    = is_aligned(sel_addr[1:0], sel_size);
  end

  assign p0_req_ready = (state == IDLE) & ~pick1;
  assign p1_req_ready = (state == IDLE) &  pick1;

  // The write strobe is gated by rst so an abandoned store never commits on the reset edge.
  assign mem_write = mem_write_q & ~rst;

  assign load_val = (req_we | req_err) ? '0 : load_extend(mem_rdata, req_off, req_size, req_uns);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      mem_read      <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_byteen    <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      req_port      <= 1'b0;
      req_we        <= 1'b0;
      req_uns       <= 1'b0;
      req_err       <= 1'b0;
      req_off       <= '0;
      req_size      <= '0;
      p0_resp_valid <= 1'b0;
      p0_resp_rdata <= '0;
      p0_resp_err   <= 1'b0;
      p1_resp_valid <= 1'b0;
      p1_resp_rdata <= '0;
      p1_resp_err   <= 1'b0;
    end else begin
      case (state)
        // Grant: latch request and pre-register the memory-side strobes for ACCESS.
        IDLE: begin
          if (accept) begin
            req_port    <= pick1;
            req_we      <= sel_we;
            req_uns     <= sel_uns;
            req_err     <= ~sel_ok;
            req_off     <= sel_addr[1:0];
            req_size    <= sel_size;
            mem_addr    <= sel_addr[WIDTH-1:2];
            mem_wdata   <= lane_data(sel_wdata, sel_size);
            mem_read    <= sel_ok & ~sel_we;
            mem_write_q <= sel_ok &  sel_we;
            mem_byteen  <= sel_ok ? lane_enables(sel_addr[1:0], sel_size) : 4'b0000;
`ifdef DMEM_ARB_FIXED_PRIO_EN
            rr_ptr      <= 1'b0;
`else
            rr_ptr      <= ~pick1;
`endif
            state       <= ACCESS;
          end
        end
        // Memory access cycle: capture load data, build the response.
        ACCESS: begin
          mem_read      <= 1'b0;
          mem_write_q   <= 1'b0;
          mem_byteen    <= 4'b0000;
          p0_resp_valid <= ~req_port;
          p0_resp_rdata <= req_port ? '0 : load_val;
          p0_resp_err   <= ~req_port & req_err;
          p1_resp_valid <= req_port;
          p1_resp_rdata <= req_port ? load_val : '0;
          p1_resp_err   <= req_port & req_err;
          state         <= RESP;
        end
        // Response strobe cycle.
        RESP: begin
          p0_resp_valid <= 1'b0;
          p0_resp_rdata <= '0;
          p0_resp_err   <= 1'b0;
          p1_resp_valid <= 1'b0;
          p1_resp_rdata <= '0;
          p1_resp_err   <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb with a behavioural single-port data memory.
module tb_dmem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_req_unsigned;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_resp_rdata;
  logic [1:0]  p0_req_size;
  logic        p0_resp_valid, p0_resp_err;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_req_unsigned;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_rdata;
  logic [1:0]  p1_req_size;
  logic        p1_resp_valid, p1_resp_err;
  logic        mem_read, mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;

  logic [31:0] mem [0:63];

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_arb #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_size(p0_req_size), .p0_req_unsigned(p0_req_unsigned),
    .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_size(p1_req_size), .p1_req_unsigned(p1_req_unsigned),
    .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .p1_resp_err(p1_resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteen(mem_byteen), .mem_rdata(mem_rdata)
  );

  // Combinational read, byte-enabled write on the rising edge.
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Response monitor: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (p0_resp_valid || p1_resp_valid) begin
      resp_t e;
      check("resp_onehot", {31'b0, p0_resp_valid & p1_resp_valid}, 32'd0);
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_port", p1_resp_valid ? 32'd1 : 32'd0, e.port);
        check("resp_rdata", p1_resp_valid ? p1_resp_rdata : p0_resp_rdata, e.rdata);
        check("resp_err", {31'b0, p1_resp_valid ? p1_resp_err : p0_resp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic drive(input int port, input logic v, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd);
    if (port == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = addr;
      p0_req_size = size; p0_req_unsigned = uns; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = addr;
      p1_req_size = size; p1_req_unsigned = uns; p1_req_wdata = wd;
    end
  endtask

  function automatic logic ready_of(input int port);
    return (port == 0) ? p0_req_ready : p1_req_ready;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction: issue, check the ACCESS-cycle memory strobes, check the N+2 response.
  task automatic do_req(input int port, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int n;
    resp_t e;
    @(negedge clk);
    drive(port, 1'b1, we, addr, size, uns, wd);
    #1;
    n = 0;
    while (!ready_of(port)) begin
      @(negedge clk); #1;
      n++;
      if (n > 20) begin
        check("ready_timeout", 32'd0, 32'd1);
        drive(port, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        return;
      end
    end
    check("ready_other", {31'b0, ready_of(1 - port)}, 32'd0);
    e.port = port; e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    check("acc_read",   {31'b0, mem_read},  {31'b0, ~exp_err & ~we});
    check("acc_write",  {31'b0, mem_write}, {31'b0, ~exp_err &  we});
    check("acc_byteen", {28'b0, mem_byteen}, {28'b0, exp_be});
    if (!exp_err) check("acc_addr", {2'b0, mem_addr}, {2'b0, addr[31:2]});
    if (!exp_err && we) check("acc_wdata", mem_wdata, exp_wd);
    @(negedge clk);
    check("resp_n2", {31'b0, ready_of(port) | (port == 0 ? p0_resp_valid : p1_resp_valid)}, 32'd1);
    check("resp_ready_low", {31'b0, p0_req_ready | p1_req_ready}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n;
    logic [31:0] exp_g;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    apply_reset();
    #1;
    check("rst_p0_valid", {31'b0, p0_resp_valid}, 32'd0);
    check("rst_p1_valid", {31'b0, p1_resp_valid}, 32'd0);
    check("rst_p0_rdata", p0_resp_rdata, 32'd0);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_byteen", {28'b0, mem_byteen}, 32'd0);
    check("rst_p0_ready", {31'b0, p0_req_ready}, 32'd1);
    check("rst_p1_ready", {31'b0, p1_req_ready}, 32'd0);

    // Word store / load round trip.
    do_req(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF);
    do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0);
    check("mem_word4", mem[4], 32'hDEADBEEF);

    // Byte loads, signed and unsigned.
    mem[4] = 32'h80FF0000;
    do_req(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 4'b1000, 32'h0);
    do_req(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 32'h00000080, 1'b0, 4'b1000, 32'h0);
    do_req(0, 1'b0, 32'h12, 2'd0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, 4'b0100, 32'h0);

    // Halfword and byte stores from port 1 and port 0, then loads.
    do_req(1, 1'b1, 32'h22, 2'd1, 1'b0, 32'h00001234, 32'h0, 1'b0, 4'b1100, 32'h12341234);
    do_req(1, 1'b0, 32'h22, 2'd1, 1'b1, 32'h0, 32'h00001234, 1'b0, 4'b1100, 32'h0);
    do_req(0, 1'b1, 32'h21, 2'd0, 1'b0, 32'h000000A5, 32'h0, 1'b0, 4'b0010, 32'hA5A5A5A5);
    do_req(0, 1'b0, 32'h20, 2'd1, 1'b0, 32'h0, 32'hFFFFA500, 1'b0, 4'b0011, 32'h0);
    check("mem_word8", mem[8], 32'h1234A500);

    // Misaligned and illegal accesses.
    do_req(0, 1'b0, 32'h06, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    do_req(0, 1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    do_req(1, 1'b1, 32'h23, 2'd1, 1'b0, 32'h0000FFFF, 32'h0, 1'b1, 4'b0000, 32'h0);
    check("mem_word8_kept", mem[8], 32'h1234A500);

    // Both ports continuously valid for four grants.
    apply_reset();
    mem[16] = 32'h0BADF00D;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (!(p0_req_ready || p1_req_ready) && n <= 20) begin
        @(negedge clk); #1;
        n++;
      end
      if (n > 20) begin
        check("arb_timeout", 32'd0, 32'd1);
        break;
      end
      check("arb_onehot", {31'b0, p0_req_ready & p1_req_ready}, 32'd0);
      g = p1_req_ready ? 1 : 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_g = 32'd0;
`else
      exp_g = (k % 2 == 0) ? 32'd0 : 32'd1;
`endif
      check("arb_grant", g, exp_g);
      begin
        resp_t e;
        e.port = g; e.rdata = 32'h0BADF00D; e.err = 1'b0;
        sb.push_back(e);
      end
      @(posedge clk);
      if (k == 3) begin
        #1;
        drive(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Reset during the ACCESS cycle of a store abandons it.
    mem[12] = 32'h11111111;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h30, 2'd2, 1'b0, 32'h22222222);
    #1;
    check("rst_mid_ready", {31'b0, p0_req_ready}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    check("rst_mid_acc_write", {31'b0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_write_gated", {31'b0, mem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_no_resp", {31'b0, p0_resp_valid | p1_resp_valid}, 32'd0);
    check("rst_mid_p0_ready", {31'b0, p0_req_ready}, 32'd1);
    check("rst_mid_mem", mem[12], 32'h11111111);
    repeat (3) @(negedge clk);

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
Name: dmem_arb

Overview:
- Arbiter and access sequencer that shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug).
- Translates byte-addressed, sized requests into word address, byte enables and lane-aligned store data.
- Extracts and sign/zero-extends load data and flags misaligned accesses.
- Sits between the requesters and the data memory. The memory read is combinational; writes commit on the rising clock edge.

Parameters:
WIDTH, 32, data/address width; memory-side word address is WIDTH-2 bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
p0_req_valid  input  1  port 0 request valid
p0_req_ready  output  1  port 0 request accepted when valid&ready
p0_req_we  input  1  1=store, 0=load
p0_req_addr  input  WIDTH  byte address
p0_req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
p0_req_unsigned  input  1  zero-extend load (lbu/lhu)
p0_req_wdata  input  WIDTH  store data, right-justified
p0_resp_valid  output  1  one-cycle response strobe
p0_resp_rdata  output  WIDTH  extended load data (0 for stores/errors)
p0_resp_err  output  1  misaligned/illegal size
p1_* : identical set for port 1
mem_read  output  1  to dmem
mem_write  output  1  to dmem
mem_addr  output  WIDTH-2  word address = req_addr[WIDTH-1:2]
mem_wdata  output  WIDTH  store data shifted to byte lane
mem_byteen  output  4  byte enables
mem_rdata  input  WIDTH  dmem combinational read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset (synchronous, rst=1 at a clock edge) forces:
  - state=IDLE, rr_ptr=0;
  - all resp_valid/resp_err=0, resp_rdata=0;
  - mem_read=mem_write=0, mem_byteen=0;
  - request register cleared.
- Reset mid-transaction abandons it. No response is issued, and no write occurs on the reset edge.
- IDLE:
  - req_ready is high for the port that would win arbitration. The other port's ready is low.
  - On accept, latch port id, we, addr, size, unsigned and wdata, then go to ACCESS.
- Arbitration when both ports are valid in IDLE:
  - the winner is the port indicated by rr_ptr;
  - after any grant, rr_ptr becomes the other port.
  - A single valid port always wins.
- ACCESS (exactly one cycle):
  - If aligned (byte: any; half: addr[0]=0; word: addr[1:0]=0; size 3 always illegal), drive mem_addr, and mem_read=!we or mem_write=we.
  - Byte enables: byte = 0001<<addr[1:0]; half = 0011<<addr[1]*2; word = 1111.
  - mem_wdata = wdata replicated into lanes (byte in every byte lane, half in both halves).
  - Load data is captured from mem_rdata at the end of ACCESS. Shift right by addr[1:0]*8, mask to size, then sign-extend unless unsigned.
  - If misaligned/illegal: mem_read=mem_write=0, byteen=0, err latched.
  - Next state is RESP.
- RESP (one cycle):
  - The granted port's resp_valid=1 with resp_rdata/resp_err. The other port's outputs stay 0.
  - Both req_ready=0. Next state is IDLE.
- Timing:
  - Accept at edge N → resp_valid high during cycle N+2.
  - Peak throughput is one transaction per 3 cycles.
  - The store is committed at the end of ACCESS.
- Outside ACCESS, mem_read, mem_write and mem_byteen are 0.
- resp_rdata holds 0 when resp_valid is 0.
- Requesters hold their request stable until ready. The arbiter never drops a valid request that it has not accepted.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests, and rr_ptr is unused and held at 0. Port 1 can starve; this is intended for debug-only configurations.
- Undefined: round-robin as above.

Test Plan:
- Reset, then p0 store word 0xDEADBEEF to addr 0x10 → ACCESS cycle shows mem_write=1, mem_addr=4, byteen=1111; p0 resp_valid at N+2, err=0. Then a p0 lw from 0x10 → rdata=0xDEADBEEF.
- p0 lb from 0x13 (word 0x80FF0000 preloaded) → byteen=1000, rdata=0xFFFFFF80. Repeat with unsigned=1 (lbu) → rdata=0x00000080.
- p1 sh 0x1234 to 0x22 → byteen=1100, mem_wdata=0x12341234. Then lhu from 0x22 → rdata=0x00001234.
- Misaligned lw at 0x06 and size=3 → no mem_read/mem_write in ACCESS, resp_err=1, rdata=0.
- Both ports valid continuously for 4 transactions → grants alternate p0,p1,p0,p1; with DMEM_ARB_FIXED_PRIO_EN, grants are p0 only.
- Assert rst during ACCESS of a store → no memory write, no resp_valid; next cycle IDLE with p0 ready.
